// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiply controller for the EX stage.
// Stalls the pipeline while a MUL iterates and presents the low WIDTH product bits.
module mul_sequencer #(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] MUL_CODE   = 4'b0100,
    parameter bit         EARLY_EXIT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             start;
    logic             last;
    logic [WIDTH-1:0] acc_nxt;

    assign start   = (state == IDLE) && valid_i && (ALUCtrl_i == MUL_CODE) && !flush_i;
    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    // Early exit looks at the multiplier after this cycle's shift.
    assign last    = (cnt == CW'(WIDTH - 1)) ||
                     (EARLY_EXIT && ((mplier >> 1) == '0));

    // Combinational so the MUL is frozen in EX from its very first cycle.
    assign stall_o = start || (state == RUN);
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= acc_nxt;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the EX-stage multiply operation (ALU control code 4'b0100) in the pipelined RV32 core.
- Detects a MUL in EX, stalls the pipeline, and runs an iterative shift-add multiply over several cycles.
- Presents the low WIDTH bits of the product to the EX result mux. All other ALU ops pass through without a stall.

Parameters:
- WIDTH, 32: operand and result width. The nominal multiply takes WIDTH iterations.
- MUL_CODE, 4'b0100: ALU control value that selects multiply.
- EARLY_EXIT, 0: when 1, the RUN state ends as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  input  1  clock. All state changes on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- valid_i  input  1  a valid instruction is in EX this cycle.
- ALUCtrl_i  input  4  ALU control code from ALU_Control.
- flush_i  input  1  EX flush. Aborts any multiply in progress.
- data1_i  input  WIDTH  multiplicand (rs1 after forwarding).
- data2_i  input  WIDTH  multiplier (rs2 after forwarding).
- stall_o  output  1  hold PC, IF/ID, ID/EX and EX operand latches.
- busy_o  output  1  FSM is not IDLE.
- done_o  output  1  one-cycle pulse: result_o is valid for the MUL currently in EX.
- result_o  output  WIDTH  product[WIDTH-1:0].

Behaviour:
- FSM states: IDLE, RUN, DONE. State is encoded as a register; there is no combinational loop.
- Reset (rst_i==0 at a clock edge), including mid-operation:
  - state=IDLE.
  - Accumulator, operand registers and counter are cleared.
  - result_o=0, done_o=0, busy_o=0, stall_o=0.
- start is defined as state==IDLE && valid_i && ALUCtrl_i==MUL_CODE && !flush_i.
- stall_o = start || state==RUN. This is combinational, so the MUL is held in EX from its first EX cycle.
- IDLE:
  - On start: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0, then go to RUN.
  - Otherwise remain in IDLE. Non-MUL ops never stall and never touch result_o.
- RUN, each cycle:
  - If mplier[0], acc <= acc + mcand, taken modulo 2^WIDTH with the carry discarded.
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - Go to DONE when cnt==WIDTH-1.
  - When EARLY_EXIT=1, also go to DONE when (mplier>>1)==0. The minimum is 1 RUN cycle, so a multiplier of 0 or 1 still passes through RUN once.
  - flush_i==1 in RUN: go to IDLE next edge, no done_o, result_o unchanged.
- DONE:
  - done_o=1, stall_o=0, and result_o = final acc.
  - The pipeline advances at this edge, so the MUL leaves EX.
  - valid_i/ALUCtrl_i are ignored in DONE, because the same MUL is still presented.
  - Go to IDLE unconditionally.
- result_o holds its value after DONE until the next DONE or a reset.
- The counter is $clog2(WIDTH)+1 bits and never wraps before DONE.
- Latency with EARLY_EXIT=0:
  - start in cycle 0; RUN in cycles 1..WIDTH; DONE in cycle WIDTH+1.
  - stall_o is high for exactly WIDTH+1 cycles (cycles 0..WIDTH).
- Back-to-back MULs: the second MUL enters EX on the edge that leaves DONE. It is seen in IDLE and starts immediately, with no bubble beyond the IDLE start cycle.
- A flush and a start in the same cycle: flush wins and no start occurs.
- Signed and unsigned operands give identical low-WIDTH results, so no sign handling is required.

Test Plan:
- Reset low for 2 cycles, then release -> all outputs 0, state IDLE, and stall_o stays 0 with valid_i=0.
- MUL 3*5 (EARLY_EXIT=0) -> stall_o high for 33 cycles, done_o pulses in cycle 33, result_o=0x0000000F and is held afterwards.
- MUL 0xFFFFFFFF*0x00000002 -> result_o=0xFFFFFFFE. MUL 0x80000000*0x2 -> result_o=0x00000000 (overflow discarded).
- ADD/SUB/AND/OR codes (0010/0110/0000/0001) with valid_i=1 -> stall_o=0, done_o=0, result_o unchanged.
- Pulse flush_i in RUN cycle 10 -> IDLE on the next cycle, no done_o. Separately, drive rst_i=0 in RUN cycle 20 -> IDLE on the next edge with outputs cleared.
- Two consecutive MULs, 7*6 then 9*9 -> done_o pulses in cycles 33 and 67, with result_o=42 then 81.
- EARLY_EXIT=1, 3*5 -> 3 RUN cycles, done_o in cycle 4, result_o=15. With 3*0 -> 1 RUN cycle, result_o=0.
